// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-path types and constants
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} fetch_state_t;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: next-pc selection (redirect vs pc+pc_inc) with alignment and misalign flag
module pc_next_calc
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_inc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] next_pc,
  output logic            misalign
);
  assign next_pc  = (redirect_valid ? redirect_pc : pc + pc_inc) & INSTR_ALIGN_MASK;
  assign misalign = !redirect_valid && (pc_inc[1:0] != 2'b00);
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and single-outstanding instruction fetch handshake
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_inc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            misalign_err
);
  fetch_state_t    state;
  logic            discard;
  logic [XLEN-1:0] next_pc;
  logic            misalign;
  logic            pc_upd;
  pc_next_calc #(.XLEN(XLEN)) u_next (
    .pc             (pc),
    .pc_inc         (pc_inc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .next_pc        (next_pc),
    .misalign       (misalign)
  );
  assign pc_upd         = redirect_valid || (state == HOLD && instr_ready);
  assign imem_req_valid = state == FETCH;
  assign instr_valid    = state == HOLD;
  assign imem_addr      = pc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      discard      <= 1'b0;
      pc           <= RESET_PC;
      instr        <= '0;
      misalign_err <= 1'b0;
    end else begin
      if (pc_upd) pc <= next_pc;
      if (pc_upd && misalign) misalign_err <= 1'b1;
      case (state)
        IDLE:  state <= FETCH;
        FETCH: if (imem_req_ready) begin
          state   <= WAIT;
          discard <= redirect_valid;
        end
        // a response that coincides with a redirect is stale and is dropped too
        WAIT: if (imem_resp_valid) begin
          discard <= 1'b0;
          if (discard || redirect_valid) state <= FETCH;
          else begin
            instr <= imem_resp_data;
            state <= HOLD;
          end
        end else if (redirect_valid) discard <= 1'b1;
        HOLD:    if (redirect_valid || instr_ready) state <= FETCH;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: randomized and directed checks against a handshake-level reference model
module tb_pc_fetch_unit;
  logic        clk = 0, rst_n = 0;
  logic        imem_req_valid, imem_req_ready = 0;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 0;
  logic [31:0] imem_resp_data = 0;
  logic        instr_valid, instr_ready = 0;
  logic [31:0] instr, pc;
  logic [31:0] pc_inc = 4;
  logic        redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  logic        misalign_err;
  always #5 clk = ~clk;
  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .pc(pc),
    .pc_inc(pc_inc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .misalign_err(misalign_err)
  );
  int tests = 0, fails = 0;
  logic [31:0] m_pc, m_instr;
  logic        m_err, m_idle, m_req, m_out, m_drop, m_have;
  int          lat = 0, cnt = 0, tick_no = 0;
  logic        force_en = 0, noise = 0, chk_en = 0, bad_seen = 0;
  logic [31:0] force_val = 0;
  int          acc_tick[$];
  logic [31:0] acc_addr[$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) if (chk_en && rst_n) begin
    check("req_valid", 32'(imem_req_valid), 32'(m_req));
    check("imem_addr", imem_addr, m_pc);
    check("instr_valid", 32'(instr_valid), 32'(m_have));
    check("pc", pc, m_pc);
    check("misalign_err", 32'(misalign_err), 32'(m_err));
    if (m_have) check("instr", instr, m_instr);
    if (instr_valid && instr == 32'hDEADBEEF) bad_seen = 1;
  end
  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_err = 0; m_idle = 1;
    m_req = 0; m_out = 0; m_drop = 0; m_have = 0; cnt = 0;
  endtask
  // one clock of stimulus; the memory answers an accepted request after 1+lat cycles
  task automatic tick(input logic rdy, input logic ir, input logic rd, input logic [31:0] rpc, input logic [31:0] inc);
    logic rv;
    logic [31:0] rdata;
    rv = 0;
    rdata = $urandom;
    if (m_out) begin
      if (cnt == 0) begin
        rv = 1;
        if (force_en) rdata = force_val;
      end else cnt--;
    end else if (noise) rv = ($urandom_range(3) == 0);
    imem_req_ready = rdy; imem_resp_valid = rv; imem_resp_data = rdata;
    instr_ready = ir; redirect_valid = rd; redirect_pc = rpc; pc_inc = inc;
    if (m_req && rdy) begin
      acc_tick.push_back(tick_no);
      acc_addr.push_back(m_pc);
    end
    if (rd) m_pc = rpc & ~32'd3;
    else if (m_have && ir) begin
      if (inc[1:0] != 2'b00) m_err = 1;
      m_pc = (m_pc + inc) & ~32'd3;
    end
    if (m_idle) begin
      m_idle = 0; m_req = 1;
    end else if (m_req) begin
      if (rdy) begin
        m_req = 0; m_out = 1; m_drop = rd; cnt = lat;
      end
    end else if (m_out) begin
      if (rv) begin
        m_out = 0;
        if (m_drop || rd) begin
          m_req = 1; m_drop = 0;
        end else begin
          m_instr = rdata; m_have = 1;
        end
      end else if (rd) m_drop = 1;
    end else if (m_have && (rd || ir)) begin
      m_have = 0; m_req = 1;
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    tick_no++;
  endtask
  task automatic wait_hold();
    int n;
    n = 0;
    while (!m_have && n < 30) begin
      tick(1, 0, 0, 0, 4);
      n++;
    end
    check("hold_reached", 32'(m_have), 1);
  endtask
  initial begin
    logic [31:0] inc;
    int r;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_pc", pc, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_req", 32'(imem_req_valid), 0);
    check("rst_iv", 32'(instr_valid), 0);
    check("rst_instr", instr, 0);
    check("rst_err", 32'(misalign_err), 0);
    rst_n = 1;
    chk_en = 1;
    repeat (10) tick(1, 1, 0, 0, 4);
    check("seq_count", 32'(acc_addr.size() >= 3), 1);
    check("seq_a0", acc_addr[0], 32'h0);
    check("seq_a1", acc_addr[1], 32'h4);
    check("seq_a2", acc_addr[2], 32'h8);
    check("seq_gap1", 32'(acc_tick[1] - acc_tick[0]), 3);
    check("seq_gap2", 32'(acc_tick[2] - acc_tick[1]), 3);
    tick(1, 0, 1, 32'hFFFF_FFFC, 4);
    wait_hold();
    check("wrap_pc_before", pc, 32'hFFFF_FFFC);
    tick(1, 1, 0, 0, 4);
    check("wrap_pc", pc, 0);
    check("wrap_err", 32'(misalign_err), 0);
    tick(1, 0, 1, 32'h10, 4);
    wait_hold();
    check("br_pc_before", pc, 32'h10);
    tick(1, 1, 0, 0, 32'hFFFF_FFF8);
    check("br_addr", imem_addr, 32'h8);
    check("br_req", 32'(imem_req_valid), 1);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 0, 4);
      check("stall_req", 32'(imem_req_valid), 1);
      check("stall_addr", imem_addr, 32'h8);
    end
    acc_addr.delete();
    lat = 2;
    force_en = 1;
    force_val = 32'hDEADBEEF;
    bad_seen = 0;
    tick(1, 0, 0, 0, 4);
    check("stall_accepts", 32'(acc_addr.size()), 1);
    check("stall_req_drop", 32'(imem_req_valid), 0);
    tick(1, 1, 1, 32'h100, 4);
    tick(1, 1, 0, 0, 4);
    check("discard_wait", 32'(imem_req_valid), 0);
    tick(1, 1, 0, 0, 4);
    acc_addr.delete();
    tick(1, 0, 0, 0, 4);
    check("redir_accepts", 32'(acc_addr.size()), 1);
    check("redir_addr", acc_addr[0], 32'h100);
    force_en = 0;
    lat = 0;
    wait_hold();
    check("redir_no_stale", 32'(bad_seen), 0);
    tick(1, 0, 1, 32'h20, 4);
    wait_hold();
    tick(1, 1, 0, 0, 6);
    check("mis_pc", pc, 32'h24);
    check("mis_err", 32'(misalign_err), 1);
    repeat (4) tick(1, 1, 0, 0, 4);
    check("mis_sticky", 32'(misalign_err), 1);
    wait_hold();
    rst_n = 0;
    #1;
    check("arst_iv", 32'(instr_valid), 0);
    check("arst_pc", pc, 0);
    check("arst_err", 32'(misalign_err), 0);
    model_reset();
    @(negedge clk);
    #1;
    noise = 1;
    rst_n = 1;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(9);
      inc = r < 6 ? 32'd4 : r < 8 ? 32'({$urandom_range(255), 2'b00}) - 32'd512 : r == 8 ? $urandom : 32'd6;
      lat = $urandom_range(2);
      tick($urandom_range(3) != 0, $urandom_range(2) != 0, $urandom_range(15) == 0, $urandom, inc);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the program counter and the instruction-fetch handshake with instruction memory.
- Presents the fetched instruction to decode and to the PC-increment mux.
- Consumes the mux's increment (4 or the branch offset) to advance the PC.
- Sits between instruction memory and the decode/increment path, closing the PC-update loop that the increment mux drives.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, address/instruction width (only 32 supported).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  XLEN  fetch address, equal to pc while a request is pending.
- imem_resp_valid  in  1  instruction data valid.
- imem_resp_data  in  XLEN  returned instruction word.
- instr_valid  out  1  instr holds a valid instruction.
- instr_ready  in  1  downstream consumes instr.
- instr  out  XLEN  current instruction; also drives the increment mux input.
- pc  out  XLEN  address of the current instruction.
- pc_inc  in  XLEN  increment from the increment mux (combinational function of instr and the zero flag).
- redirect_valid  in  1  external redirect (trap/jump).
- redirect_pc  in  XLEN  redirect target.
- misalign_err  out  1  sticky error flag.

Behaviour:
- Reset (rst_n=0, asynchronous) drives:
  - pc=RESET_PC, imem_addr=RESET_PC.
  - imem_req_valid=0, instr_valid=0, instr=0, misalign_err=0.
  - state=IDLE, discard flag=0.
- FSM states: IDLE, FETCH, WAIT, HOLD. All outputs are registered or decoded from the registered state.
  - IDLE → FETCH unconditionally on the next edge.
  - FETCH:
    - imem_req_valid=1 and imem_addr=pc.
    - On imem_req_valid & imem_req_ready, go to WAIT; otherwise stay and hold the address stable.
  - WAIT:
    - On imem_resp_valid with the discard flag clear: instr<=imem_resp_data, go to HOLD.
    - On imem_resp_valid with the discard flag set: drop the data, clear the discard flag, go to FETCH.
  - HOLD:
    - instr_valid=1.
    - On instr_ready: pc<=pc+pc_inc (pc_inc sampled that cycle), instr_valid<=0, go to FETCH.
- Earliest response is one cycle after request acceptance. With zero-wait memory and instr_ready tied high, throughput is one instruction per 3 cycles.
- Addition is modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- If pc_inc[1:0]≠0 at PC update:
  - misalign_err<=1 (sticky until reset).
  - pc<=(pc+pc_inc) & ~3.
- redirect_valid has priority over every other PC update in all states:
  - pc<=redirect_pc & ~3; instr_valid<=0.
  - From FETCH or HOLD: go to FETCH.
  - From WAIT: set the discard flag and stay in WAIT until the outstanding response arrives. Only one outstanding request is ever allowed.
  - Redirect coincident with instr_ready in HOLD: the redirect wins and pc_inc is ignored.
  - Redirect in FETCH coincident with request acceptance: the accepted request is treated as outstanding; go to WAIT with the discard flag set.
- No new request is issued while in WAIT, even after a redirect.
- Reset asserted mid-transaction: immediate return to reset values. A late memory response after reset release is ignored because the state is IDLE/FETCH, not WAIT.

Decomposition:
- fetch_pkg holds:
  - fetch state enum (IDLE/FETCH/WAIT/HOLD).
  - RESET_PC default.
  - INSTR_ALIGN_MASK = 32'hFFFF_FFFC.
  - OPCODE_BRANCH = 7'b1100011, shared with the increment mux and decode.
- One natural sub-module: pc_next_calc (combinational). It selects redirect vs pc+pc_inc, applies the alignment mask, and flags misalignment. The FSM and registers stay in pc_fetch_unit.

Test Plan:
- Reset release, memory always ready with one-cycle response, pc_inc=4, instr_ready=1 → imem_addr sequence 0x0, 0x4, 0x8, with instr_valid pulsing once every 3 cycles.
- Branch taken, pc_inc=32'hFFFF_FFF8 at pc=0x10 → next imem_addr=0x08.
- imem_req_ready low for 5 cycles in FETCH → imem_req_valid held high and imem_addr stable for 5 cycles; a single request is accepted.
- redirect_valid with redirect_pc=0x100 while in WAIT; response data 0xDEADBEEF arrives 2 cycles later → 0xDEADBEEF never appears on instr with instr_valid; next request address is 0x100.
- pc_inc=6 at pc=0x20 → misalign_err=1 (stays 1); next pc=0x24.
- pc=0xFFFF_FFFC, pc_inc=4 → next pc=0x0 with no error; rst_n pulsed low during HOLD → instr_valid drops immediately and pc=RESET_PC.
